wb_b3_burst_master: RTL



---
 rtl/wb_b3_pkg.sv | 39 +++
 rtl/wb_b3_adr_gen.sv | 24 ++
 rtl/wb_b3_burst_master.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 encodings and burst-master state for the bus master and its address generator.
package wb_b3_pkg;

  localparam int unsigned BEAT_W = 5;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  localparam logic [1:0] STAT_OK  = 2'b00;
  localparam logic [1:0] STAT_ERR = 2'b01;
  localparam logic [1:0] STAT_RTY = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_END  = 2'd2
  } state_e;

  // Wrap bursts have a fixed length; linear bursts take the requested count, zero meaning one.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [1:0] bte,
                                                    input logic [BEAT_W-1:0] len);
    logic [BEAT_W-1:0] beats;
    unique case (bte)
      BTE_WRAP4:  beats = BEAT_W'(4);
      BTE_WRAP8:  beats = BEAT_W'(8);
      BTE_WRAP16: beats = BEAT_W'(16);
      default:    beats = (len == '0) ? BEAT_W'(1) : len;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/wb_b3_adr_gen.sv
// Next-beat address for a Wishbone B3 burst: linear word increment or 4/8/16-word wrap.
module wb_b3_adr_gen
  import wb_b3_pkg::*;
#(
  parameter int unsigned aw = 32
) (
  input  logic [aw-1:0] adr_i,
  input  logic [1:0]    bte_i,
  output logic [aw-1:0] adr_nxt_o
);

  // Wrap modes only touch the word index inside the wrap window; upper bits are kept.
  always_comb begin
    adr_nxt_o = adr_i;
    unique case (bte_i)
      BTE_LINEAR: adr_nxt_o      = adr_i + aw'(4);
      BTE_WRAP4:  adr_nxt_o[3:2] = adr_i[3:2] + 2'd1;
      BTE_WRAP8:  adr_nxt_o[4:2] = adr_i[4:2] + 3'd1;
      BTE_WRAP16: adr_nxt_o[5:2] = adr_i[5:2] + 4'd1;
      default:    adr_nxt_o      = adr_i;
    endcase
  end

endmodule

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 initiator: turns one command into a classic, linear or wrap burst cycle
// and reports completion with ok/err/rty status.
module wb_b3_burst_master
  import wb_b3_pkg::*;
#(
  parameter int unsigned dw    = 32,
  parameter int unsigned aw    = 32,
  parameter int unsigned len_w = 5
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [aw-1:0]    cmd_adr,
  input  logic [3:0]       cmd_sel,
  input  logic [len_w-1:0] cmd_len,
  input  logic [1:0]       cmd_bte,
  input  logic [dw-1:0]    wdat,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  output logic [dw-1:0]    rdat,
  output logic             rdat_valid,
  output logic             done,
  output logic [1:0]       status,
  output logic [aw-1:0]    wb_adr_o,
  output logic [dw-1:0]    wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_cti_o,
  output logic [1:0]       wb_bte_o,
  input  logic [dw-1:0]    wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [1:0]        bte_q, bte_d;
  logic [1:0]        wb_bte_q, wb_bte_d;
  logic [aw-1:0]     adr_q, adr_d;
  logic [aw-1:0]     adr_nxt;
  logic              cyc_q, cyc_d;
  logic [2:0]        cti_q, cti_d;
  logic [1:0]        status_q, status_d;
  logic [dw-1:0]     rdat_q, rdat_d;
  logic              rdat_valid_q, rdat_valid_d;
  logic              cmd_ready_q;
  logic              done_q;

  logic              in_bus;
  logic              stb_c;
  logic              beat_err;
  logic              beat_rty;
  logic              beat_ack;
  logic              accept;
  logic [BEAT_W-1:0] cmd_beats;
  logic              unused_adr_lsb;

  assign unused_adr_lsb = ^cmd_adr[1:0];

  // A write beat is only strobed while the source has a word ready; reads always strobe.
  assign in_bus   = (state_q == ST_BUS);
  assign stb_c    = in_bus & (~we_q | wdat_valid);
  assign beat_err = stb_c & wb_err_i;
  assign beat_rty = stb_c & ~wb_err_i & wb_rty_i;
  assign beat_ack = stb_c & ~wb_err_i & ~wb_rty_i & wb_ack_i;
  assign accept   = (state_q == ST_IDLE) & cmd_valid & cmd_ready_q;

  assign cmd_beats = burst_beats(cmd_bte, BEAT_W'(cmd_len));

  wb_b3_adr_gen #(
    .aw(aw)
  ) u_adr_gen (
    .adr_i    (adr_q),
    .bte_i    (bte_q),
    .adr_nxt_o(adr_nxt)
  );

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    we_d         = we_q;
    sel_d        = sel_q;
    bte_d        = bte_q;
    wb_bte_d     = wb_bte_q;
    adr_d        = adr_q;
    cyc_d        = cyc_q;
    cti_d        = cti_q;
    status_d     = STAT_OK;
    rdat_d       = rdat_q;
    rdat_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_BUS;
          we_d     = cmd_we;
          sel_d    = cmd_sel;
          bte_d    = cmd_bte;
          adr_d    = {cmd_adr[aw-1:2], 2'b00};
          beats_d  = cmd_beats;
          cyc_d    = 1'b1;
          cti_d    = (cmd_beats == BEAT_W'(1)) ? CTI_CLASSIC : CTI_INCR;
          wb_bte_d = (cmd_beats == BEAT_W'(1)) ? BTE_LINEAR : cmd_bte;
        end
      end

      ST_BUS: begin
        // Error and retry end the cycle without recording a beat; the caller decides on retries.
        if (beat_err || beat_rty) begin
          state_d  = ST_END;
          cyc_d    = 1'b0;
          cti_d    = CTI_CLASSIC;
          status_d = beat_err ? STAT_ERR : STAT_RTY;
        end else if (beat_ack) begin
          if (!we_q) begin
            rdat_d       = wb_dat_i;
            rdat_valid_d = 1'b1;
          end
          if (beats_q <= BEAT_W'(1)) begin
            state_d = ST_END;
            beats_d = '0;
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
          end else begin
            beats_d = beats_q - BEAT_W'(1);
            adr_d   = adr_nxt;
            cti_d   = (beats_q == BEAT_W'(2)) ? CTI_EOB : CTI_INCR;
          end
        end
      end

      ST_END: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      beats_q      <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      bte_q        <= BTE_LINEAR;
      wb_bte_q     <= BTE_LINEAR;
      adr_q        <= '0;
      cyc_q        <= 1'b0;
      cti_q        <= CTI_CLASSIC;
      status_q     <= STAT_OK;
      rdat_q       <= '0;
      rdat_valid_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      bte_q        <= bte_d;
      wb_bte_q     <= wb_bte_d;
      adr_q        <= adr_d;
      cyc_q        <= cyc_d;
      cti_q        <= cti_d;
      status_q     <= status_d;
      rdat_q       <= rdat_d;
      rdat_valid_q <= rdat_valid_d;
      cmd_ready_q  <= (state_d == ST_IDLE);
      done_q       <= (state_d == ST_END);
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign wdat_ready = beat_ack & we_q;
  assign rdat       = rdat_q;
  assign rdat_valid = rdat_valid_q;
  assign done       = done_q;
  assign status     = status_q;

  assign wb_adr_o = adr_q;
  assign wb_dat_o = (in_bus && we_q) ? wdat : '0;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_c;
  assign wb_cti_o = cti_q;
  assign wb_bte_o = wb_bte_q;

endmodule
